// File: rtl/conv2_wstream_pkg.sv
// Shared types and constants for the conv2 weight streamer.
// No logic, so no latency.
// No flow control; carries only definitions.
package conv2_wstream_pkg;

   // Controller modes.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_NUM_WORDS  = 200;

   // Output buffer depth. The read credit rule in the top level assumes exactly 2.
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/conv2_wstream_fifo.sv
// 2-entry FIFO holding {last, data} read-backs from the weight SRAM.
// Head is visible the cycle after a push (registered storage, combinational head).
// No internal backpressure: the writer must never push into a full FIFO unless it also pops.
module conv2_wstream_fifo
   import conv2_wstream_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH + 1
)(
   input  logic             clk0,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic             wr_idx_q;
   logic             rd_idx_q;
   logic [1:0]       count_q;

   // Storage, pointers and occupancy. When full, push and pop share a slot:
   // the old head is consumed this cycle while the new word lands in its place.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_idx_q <= 1'b0;
         rd_idx_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_idx_q] <= push_dat;
            wr_idx_q        <= ~wr_idx_q;
         end
         if (pop) begin
            rd_idx_q <= ~rd_idx_q;
         end
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

   assign head  = mem_q[rd_idx_q];
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);

endmodule

// File: rtl/conv2_weight_streamer.sv
// Fills the conv2 weight SRAM from a load stream, then replays it pass_count times to the MAC.
// Load: one write per accepted word; replay: first m_valid 2 cycles after entering STREAM, then 1 word/cycle.
// m_ready low stalls reads via a 2-credit rule, never drops data. Optional checksum: CONV2_WSTREAM_CHECKSUM_EN.
module conv2_weight_streamer
   import conv2_wstream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WORDS  = DEF_NUM_WORDS
)(
   input  logic                  clk0,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  stream_start,
   input  logic [7:0]            pass_count,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
`ifdef CONV2_WSTREAM_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [7:0]            pass_ctr_q;
   logic [7:0]            pass_total_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  done_q;

   logic                  wr_en;
   logic                  rd_en;
   logic                  pop;
   logic                  can_read;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH:0]   fifo_head;

   // Read credit: words in flight plus buffered, minus this cycle's pop, must stay below 2
   // so the unconditional capture of dout0 always finds space. Counting the pop keeps
   // the stream gap-free when m_ready is held high.
   assign pop      = m_valid & m_ready;
   assign can_read = pop | (~fifo_full & (fifo_empty | ~inflight_q));

   // Next-state and SRAM port decode; all SRAM signals are combinational.
   always_comb begin
      state_d = state_q;
      csb0    = 1'b1;
      web0    = 1'b1;
      addr0   = '0;
      din0    = '0;
      s_ready = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
            end else if (stream_start) begin
               state_d = STREAM;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               csb0  = 1'b0;
               web0  = 1'b0;
               addr0 = wr_ptr_q;
               din0  = s_data;
               wr_en = 1'b1;
               if (wr_ptr_q == LAST_ADDR) begin
                  state_d = IDLE;
               end
            end
         end
         STREAM: begin
            if (can_read) begin
               csb0  = 1'b0;
               addr0 = rd_ptr_q;
               rd_en = 1'b1;
               if ((rd_ptr_q == LAST_ADDR) && (pass_ctr_q == pass_total_q - 8'd1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty && !inflight_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointers, pass bookkeeping, read tracking and the done pulse.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         pass_ctr_q      <= 8'd0;
         pass_total_q    <= 8'd1;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         done_q          <= (state_q != IDLE) && (state_d == IDLE);
         inflight_q      <= rd_en;
         inflight_last_q <= rd_en && (rd_ptr_q == LAST_ADDR);
         if (state_q == IDLE && state_d == LOAD) begin
            wr_ptr_q <= '0;
         end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         end
         if (state_q == IDLE && state_d == STREAM) begin
            rd_ptr_q     <= '0;
            pass_ctr_q   <= 8'd0;
            pass_total_q <= (pass_count == 8'd0) ? 8'd1 : pass_count;
         end else if (rd_en) begin
            if (rd_ptr_q == LAST_ADDR) begin
               rd_ptr_q   <= '0;
               pass_ctr_q <= pass_ctr_q + 8'd1;
            end else begin
               rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
         end
      end
   end

   conv2_wstream_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk0     (clk0),
      .rst_n    (rst_n),
      .push     (inflight_q),
      .push_dat ({inflight_last_q, dout0}),
      .pop      (pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign m_valid = ~fifo_empty;
   assign m_data  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
   assign m_last  = fifo_empty ? 1'b0 : fifo_head[DATA_WIDTH];
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

`ifdef CONV2_WSTREAM_CHECKSUM_EN
   // Running sum of delivered words; cleared when a replay is accepted, held afterwards.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (state_q == IDLE && state_d == STREAM) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum + m_data;
      end
   end
`endif

endmodule
